ctrl_seq: RTL

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: fetches 9-bit instructions and drives ALU/regfile/memory enables.
// Latency: 2 cycles per instruction (FETCH, EXEC); LW/SW take 3 (extra MEM cycle).
// Backpressure: none; Start is honoured only in IDLE/HALT, branch_en is sampled in EXEC.
module ctrl_seq (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Start,
    input  logic [8:0] instr,
    input  logic       branch_en,
    output logic [7:0] pc,
    output logic [3:0] OP,
    output logic       reg_exe,
    output logic       imm_exe,
    output logic       reg_to_acc,
    output logic       acc_to_reg,
    output logic [3:0] reg_addr,
    output logic [7:0] imm_out,
    output logic       acc_we,
    output logic       reg_we,
    output logic       sc_we,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       done
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_BEQ  = 4'd2;
    localparam logic [3:0] OP_SL   = 4'd3;
    localparam logic [3:0] OP_SR   = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_ASGN = 4'd8;
    localparam logic [3:0] OP_BGE  = 4'd9;
    localparam logic [3:0] OP_BNE  = 4'd10;
    localparam logic [3:0] OP_AND  = 4'd11;
    localparam logic [3:0] OP_OR   = 4'd12;
    localparam logic [3:0] OP_JMP  = 4'd13;
    localparam logic [3:0] OP_HALT = 4'd14;
    localparam logic [3:0] OP_NOP  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [8:0] ir_q, ir_d;
    logic       acc_en, reg_en, sc_en, rd_en, wr_en;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= 8'd0;
            ir_q    <= 9'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_en  = 1'b0;
        reg_en  = 1'b0;
        sc_en   = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    pc_d    = 8'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + 8'd1;
                case (ir_q[8:5])
                    OP_ADD, OP_SUB, OP_SL, OP_SR: begin
                        acc_en = 1'b1;
                        sc_en  = 1'b1;
                    end
                    OP_AND, OP_OR, OP_ASGN: acc_en = 1'b1;
                    OP_MOV: begin
                        acc_en = ir_q[4];
                        reg_en = ~ir_q[4];
                    end
                    // branch_en = 1 skips the following instruction
                    OP_BEQ, OP_BGE, OP_BNE: pc_d = pc_q + (branch_en ? 8'd2 : 8'd1);
                    OP_JMP: pc_d = {ir_q[4:0], 3'b000};
                    OP_LW: begin
                        rd_en   = 1'b1;
                        pc_d    = pc_q;
                        state_d = S_MEM;
                    end
                    OP_SW: begin
                        wr_en   = 1'b1;
                        pc_d    = pc_q;
                        state_d = S_MEM;
                    end
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    OP_NOP: ;
                    default: ;
                endcase
            end
            S_MEM: begin
                acc_en  = (ir_q[8:5] == OP_LW);
                pc_d    = pc_q + 8'd1;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Enables are masked while Reset is high so no write can slip out around a reset
    assign acc_we = acc_en & ~Reset;
    assign reg_we = reg_en & ~Reset;
    assign sc_we  = sc_en  & ~Reset;
    assign mem_rd = rd_en  & ~Reset;
    assign mem_wr = wr_en  & ~Reset;

    assign pc         = pc_q;
    assign OP         = ir_q[8:5];
    assign reg_exe    = ir_q[4];
    assign imm_exe    = ~ir_q[4];
    assign reg_addr   = ir_q[3:0];
    assign imm_out    = {4'b0000, ir_q[3:0]};
    assign reg_to_acc = (ir_q[8:5] == OP_MOV) &  ir_q[4];
    assign acc_to_reg = (ir_q[8:5] == OP_MOV) & ~ir_q[4];
    assign done       = (state_q == S_HALT);

endmodule
